// File: rtl/cdc_speed_pkg.sv
// Shared types and constants for the speed-config clock-domain crossing.
// Build option: define CDC_SPEED_TIMEOUT_EN to enable the ack timeout / abort logic.
package cdc_speed_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam int DEFAULT_ACK_TIMEOUT = 255;
    localparam int MIN_TIMEOUT_CNT_W   = 8;

    // Counter width: wide enough for the timeout value, never narrower than 8 bits.
    function automatic int timeout_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > MIN_TIMEOUT_CNT_W) ? w : MIN_TIMEOUT_CNT_W;
    endfunction

endpackage

// File: rtl/cdc_sync_bits.sv
// Multi-flop synchronizer for level signals arriving from another clock domain.
// Each bit must be independently meaningful; never use this for multi-bit data words.
module cdc_sync_bits #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

    // Shift the asynchronous input one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // Synchronizer chain; cleared so a stale remote level is not seen during reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_speed_config_sender.sv
// Source-domain end of the speed-config crossing: accepts a config word via valid/ready,
// holds it on cdc_data and moves it with a 4-phase level req/ack handshake.
// Build option: `CDC_SPEED_TIMEOUT_EN adds a per-phase ack timeout with sticky timeout_err.
module cdc_speed_config_sender
    import cdc_speed_pkg::*;
#(
    parameter int NUM_OF_BITS = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                   in_clk,
    input  logic                   in_reset,
    input  logic [NUM_OF_BITS-1:0] cfg_in,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   cfg_done,
    output logic [NUM_OF_BITS-1:0] cdc_data,
    output logic                   cdc_req,
    input  logic                   cdc_ack,
    output logic                   timeout_err
);

    state_t                 state_q, state_d;
    logic                   cdc_req_q, cdc_req_d;
    logic [NUM_OF_BITS-1:0] cdc_data_q, cdc_data_d;
    logic [NUM_OF_BITS-1:0] last_cfg_q, last_cfg_d;
    logic                   cfg_done_q, cfg_done_d;
    logic                   ack_s;

`ifdef CDC_SPEED_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_width(ACK_TIMEOUT);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [NUM_OF_BITS-1:0] prev_cfg_q, prev_cfg_d;
    logic                   drain_q, drain_d;
    logic                   timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = ^ACK_TIMEOUT;
`endif

    cdc_sync_bits #(
        .WIDTH       (1),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (in_clk),
        .rst (in_reset),
        .d   (cdc_ack),
        .q   (ack_s)
    );

    // A stale high ack (remote side not reset with us) must drop before a new word starts.
    assign cfg_ready = (state_q == IDLE) && !ack_s;

    // Handshake sequencing: accept/skip in IDLE, wait ack high, then wait ack low.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cdc_req_d  = cdc_req_q;
        cdc_data_d = cdc_data_q;
        last_cfg_d = last_cfg_q;
        cfg_done_d = 1'b0;
`ifdef CDC_SPEED_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
        prev_cfg_d    = prev_cfg_q;
        drain_d       = drain_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef CDC_SPEED_TIMEOUT_EN
                drain_d = 1'b0;
`endif
                if (cfg_valid && cfg_ready) begin
                    if (cfg_in == last_cfg_q) begin
                        // Destination already holds this code; just acknowledge upstream.
                        cfg_done_d = 1'b1;
                    end else begin
                        cdc_data_d = cfg_in;
                        last_cfg_d = cfg_in;
                        cdc_req_d  = 1'b1;
                        state_d    = REQ_HI;
`ifdef CDC_SPEED_TIMEOUT_EN
                        prev_cfg_d = last_cfg_q;
`endif
                    end
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    cdc_req_d = 1'b0;
                    state_d   = REQ_LO;
                end
`ifdef CDC_SPEED_TIMEOUT_EN
                else if (timeout_hit) begin
                    // Abort: withdraw the request, drain any late ack, allow a retry.
                    timeout_err_d = 1'b1;
                    cdc_req_d     = 1'b0;
                    last_cfg_d    = prev_cfg_q;
                    drain_d       = 1'b1;
                    state_d       = REQ_LO;
                end
`endif
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
`ifdef CDC_SPEED_TIMEOUT_EN
                    cfg_done_d = !drain_q;
`else
                    cfg_done_d = 1'b1;
`endif
                end
`ifdef CDC_SPEED_TIMEOUT_EN
                else if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                    last_cfg_d    = prev_cfg_q;
                    state_d       = IDLE;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                cdc_req_d = 1'b0;
            end
        endcase
`ifdef CDC_SPEED_TIMEOUT_EN
        // Restart the phase timer on every state entry; it only runs while waiting for ack.
        if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`endif
    end

    // Handshake and data registers; cdc_data comes straight from a flop so it never glitches.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q    <= IDLE;
            cdc_req_q  <= 1'b0;
            cdc_data_q <= '0;
            last_cfg_q <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cdc_req_q  <= cdc_req_d;
            cdc_data_q <= cdc_data_d;
            last_cfg_q <= last_cfg_d;
            cfg_done_q <= cfg_done_d;
        end
    end

`ifdef CDC_SPEED_TIMEOUT_EN
    // Timeout bookkeeping: phase counter, sticky error, pre-accept code for rollback.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            prev_cfg_q    <= '0;
            drain_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            prev_cfg_q    <= prev_cfg_d;
            drain_q       <= drain_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign cdc_req  = cdc_req_q;
    assign cdc_data = cdc_data_q;
    assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_cdc_speed_config_sender.sv
// Directed testbench for cdc_speed_config_sender with a small destination-side ack model.
// Build option: define CDC_SPEED_TIMEOUT_EN to exercise the timeout path (ACK_TIMEOUT=16).
module tb_cdc_speed_config_sender;

`ifdef CDC_SPEED_TIMEOUT_EN
    localparam int TB_ACK_TIMEOUT = 16;
`else
    localparam int TB_ACK_TIMEOUT = 255;
`endif
    localparam int ACK_DELAY = 3;
    // Accept edge to cfg_done: 2*(SYNC_STAGES + ACK_DELAY) + 2 = 12 cycles.
    localparam int ROUND_TRIP = 12;

    logic       in_clk    = 1'b0;
    logic       in_reset  = 1'b1;
    logic [1:0] cfg_in    = 2'b00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_done;
    logic [1:0] cdc_data;
    logic       cdc_req;
    logic       cdc_ack   = 1'b0;
    logic       timeout_err;

    int passed = 0;
    int total  = 0;

    bit auto_en    = 1'b1;
    bit force_high = 1'b0;
    int ack_cnt    = 0;

    int         stable_viol = 0;
    int         done_cnt    = 0;
    logic       prev_req    = 1'b0;
    logic [1:0] prev_data   = 2'b00;

    cdc_speed_config_sender #(
        .NUM_OF_BITS (2),
        .SYNC_STAGES (2),
        .ACK_TIMEOUT (TB_ACK_TIMEOUT)
    ) dut (
        .in_clk      (in_clk),
        .in_reset    (in_reset),
        .cfg_in      (cfg_in),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_done    (cfg_done),
        .cdc_data    (cdc_data),
        .cdc_req     (cdc_req),
        .cdc_ack     (cdc_ack),
        .timeout_err (timeout_err)
    );

    always #5 in_clk = ~in_clk;

    // Destination model: ack follows req ACK_DELAY cycles after req changes.
    always @(posedge in_clk) begin
        if (force_high) begin
            cdc_ack <= 1'b1;
            ack_cnt <= 0;
        end else if (auto_en && (cdc_req !== cdc_ack)) begin
            if (ack_cnt == ACK_DELAY - 1) begin
                cdc_ack <= cdc_req;
                ack_cnt <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    // Monitor: cdc_data must not move while cdc_req stays high; count cfg_done pulses.
    always @(negedge in_clk) begin
        if (!in_reset && prev_req && cdc_req && (cdc_data !== prev_data)) stable_viol++;
        if (cfg_done === 1'b1) done_cnt++;
        prev_req  = cdc_req;
        prev_data = cdc_data;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < bound) begin
            tick();
            cycles++;
            if (cfg_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        in_reset  = 1'b1;
        cfg_valid = 1'b0;
        repeat (3) tick();
        total++; if (cdc_req !== 1'b0) $display("FAIL reset_req: got %b, want 0", cdc_req); else passed++;
        total++; if (cdc_data !== 2'b00) $display("FAIL reset_data: got %b, want 00", cdc_data); else passed++;
        total++; if (cfg_done !== 1'b0) $display("FAIL reset_done: got %b, want 0", cfg_done); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL reset_terr: got %b, want 0", timeout_err); else passed++;
        in_reset = 1'b0;
        repeat (3) tick();
        total++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b, want 1", cfg_ready); else passed++;
    endtask

    task automatic test_first_transfer();
        int cycles;
        bit seen;
        int d0;
        d0 = done_cnt;
        cfg_in    = 2'b10;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        total++; if (cdc_req !== 1'b1) $display("FAIL t1_req_rise: got %b, want 1", cdc_req); else passed++;
        total++; if (cdc_data !== 2'b10) $display("FAIL t1_data: got %b, want 10", cdc_data); else passed++;
        total++; if (cfg_ready !== 1'b0) $display("FAIL t1_ready_busy: got %b, want 0", cfg_ready); else passed++;
        wait_done(100, cycles, seen);
        total++; if (!seen || cycles != ROUND_TRIP) $display("FAIL t1_round_trip: got seen=%0b cycles=%0d, want 1/%0d", seen, cycles, ROUND_TRIP); else passed++;
        total++; if (cfg_ready !== 1'b1) $display("FAIL t1_ready_back: got %b, want 1", cfg_ready); else passed++;
        total++; if (cdc_req !== 1'b0) $display("FAIL t1_req_low: got %b, want 0", cdc_req); else passed++;
        tick();
        total++; if (cfg_done !== 1'b0) $display("FAIL t1_done_width: got %b, want 0", cfg_done); else passed++;
        total++; if (done_cnt - d0 != 1) $display("FAIL t1_done_count: got %0d, want 1", done_cnt - d0); else passed++;
        total++; if (cdc_data !== 2'b10) $display("FAIL t1_data_held: got %b, want 10", cdc_data); else passed++;
    endtask

    task automatic test_same_code();
        bit any_req;
        cfg_in    = 2'b10;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        total++; if (cfg_done !== 1'b1) $display("FAIL t2_skip_done: got %b, want 1", cfg_done); else passed++;
        total++; if (cdc_req !== 1'b0) $display("FAIL t2_skip_req: got %b, want 0", cdc_req); else passed++;
        any_req = 1'b0;
        tick();
        total++; if (cfg_done !== 1'b0) $display("FAIL t2_done_width: got %b, want 0", cfg_done); else passed++;
        repeat (5) begin
            if (cdc_req !== 1'b0) any_req = 1'b1;
            tick();
        end
        total++; if (any_req !== 1'b0) $display("FAIL t2_no_req_activity: got %b, want 0", any_req); else passed++;
        total++; if (cfg_ready !== 1'b1) $display("FAIL t2_ready: got %b, want 1", cfg_ready); else passed++;
    endtask

    task automatic test_hold_during_transfer();
        int cycles;
        bit seen;
        cfg_in    = 2'b00;
        cfg_valid = 1'b1;
        tick();
        total++; if (cdc_data !== 2'b00 || cdc_req !== 1'b1) $display("FAIL t3_first_accept: got req=%b data=%b, want 1/00", cdc_req, cdc_data); else passed++;
        cfg_in = 2'b01;
        wait_done(100, cycles, seen);
        total++; if (!seen || cycles != ROUND_TRIP) $display("FAIL t3_round_trip: got seen=%0b cycles=%0d, want 1/%0d", seen, cycles, ROUND_TRIP); else passed++;
        total++; if (cdc_data !== 2'b00) $display("FAIL t3_not_captured: got %b, want 00", cdc_data); else passed++;
        tick();
        cfg_valid = 1'b0;
        total++; if (cdc_req !== 1'b1 || cdc_data !== 2'b01) $display("FAIL t3_second_accept: got req=%b data=%b, want 1/01", cdc_req, cdc_data); else passed++;
        wait_done(100, cycles, seen);
        total++; if (!seen) $display("FAIL t3_second_done: got 0, want 1"); else passed++;
    endtask

    task automatic test_stale_ack();
        int cycles;
        bit seen;
        force_high = 1'b1;
        in_reset   = 1'b1;
        repeat (4) tick();
        in_reset = 1'b0;
        repeat (3) tick();
        total++; if (cfg_ready !== 1'b0) $display("FAIL t4_ready_blocked: got %b, want 0", cfg_ready); else passed++;
        cfg_in    = 2'b01;
        cfg_valid = 1'b1;
        repeat (5) tick();
        total++; if (cdc_req !== 1'b0 || cdc_data !== 2'b00) $display("FAIL t4_not_accepted: got req=%b data=%b, want 0/00", cdc_req, cdc_data); else passed++;
        force_high = 1'b0;
        cycles = 0;
        while (cdc_req !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        cfg_valid = 1'b0;
        total++; if (cycles != 6) $display("FAIL t4_accept_latency: got %0d, want 6", cycles); else passed++;
        total++; if (cdc_data !== 2'b01) $display("FAIL t4_data: got %b, want 01", cdc_data); else passed++;
        wait_done(100, cycles, seen);
        total++; if (!seen) $display("FAIL t4_done: got 0, want 1"); else passed++;
    endtask

`ifdef CDC_SPEED_TIMEOUT_EN
    task automatic test_timeout();
        int cycles;
        bit seen;
        int d0;
        auto_en   = 1'b0;
        cfg_in    = 2'b10;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        d0 = done_cnt;
        total++; if (cdc_req !== 1'b1) $display("FAIL t5_req: got %b, want 1", cdc_req); else passed++;
        repeat (15) tick();
        total++; if (timeout_err !== 1'b0 || cdc_req !== 1'b1) $display("FAIL t5_before_limit: got terr=%b req=%b, want 0/1", timeout_err, cdc_req); else passed++;
        tick();
        total++; if (timeout_err !== 1'b1 || cdc_req !== 1'b0) $display("FAIL t5_at_limit: got terr=%b req=%b, want 1/0", timeout_err, cdc_req); else passed++;
        repeat (3) tick();
        total++; if (done_cnt != d0) $display("FAIL t5_no_done: got %0d pulses, want 0", done_cnt - d0); else passed++;
        total++; if (cfg_ready !== 1'b1) $display("FAIL t5_ready: got %b, want 1", cfg_ready); else passed++;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        total++; if (cdc_req !== 1'b1 || cdc_data !== 2'b10) $display("FAIL t5_retry: got req=%b data=%b, want 1/10", cdc_req, cdc_data); else passed++;
        auto_en = 1'b1;
        wait_done(100, cycles, seen);
        total++; if (!seen) $display("FAIL t5_retry_done: got 0, want 1"); else passed++;
        total++; if (timeout_err !== 1'b1) $display("FAIL t5_sticky: got %b, want 1", timeout_err); else passed++;
    endtask
`else
    task automatic test_no_timeout();
        int cycles;
        bit seen;
        auto_en   = 1'b0;
        cfg_in    = 2'b10;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (300) tick();
        total++; if (cdc_req !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL t5_waits: got req=%b ready=%b, want 1/0", cdc_req, cfg_ready); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL t5_terr_tied: got %b, want 0", timeout_err); else passed++;
        auto_en = 1'b1;
        wait_done(100, cycles, seen);
        total++; if (!seen) $display("FAIL t5_late_done: got 0, want 1"); else passed++;
    endtask
`endif

    task automatic test_reset_mid_transfer();
        cfg_in    = 2'b01;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (2) tick();
        total++; if (cdc_req !== 1'b1) $display("FAIL t6_in_req_hi: got %b, want 1", cdc_req); else passed++;
        #2;
        in_reset = 1'b1;
        #1;
        total++; if (cdc_req !== 1'b0 || cdc_data !== 2'b00) $display("FAIL t6_async_clear: got req=%b data=%b, want 0/00", cdc_req, cdc_data); else passed++;
        total++; if (cfg_ready !== 1'b1 || timeout_err !== 1'b0) $display("FAIL t6_idle: got ready=%b terr=%b, want 1/0", cfg_ready, timeout_err); else passed++;
        repeat (10) tick();
        in_reset = 1'b0;
        repeat (3) tick();
        cfg_in    = 2'b00;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        total++; if (cfg_done !== 1'b1 || cdc_req !== 1'b0) $display("FAIL t6_zero_skip: got done=%b req=%b, want 1/0", cfg_done, cdc_req); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_transfer();
        test_same_code();
        test_hold_during_transfer();
        test_stale_ack();
`ifdef CDC_SPEED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_transfer();
        total++; if (stable_viol != 0) $display("FAIL data_stable_while_req: got %0d changes, want 0", stable_viol); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
